pipeline_ctrl: RTL and testbench

Central pipeline control unit for the five-stage RV32 core. It turns per-stage stall requests into the `ctrl_stall[4:0]` vector consumed by the stage registers (if_id, id_ex, ex_mem, mem_wb). It also sequences trap entry and `mret` through a small state machine that drives `ctrl_flush`, the PC redirect and the CSR trap-update strobes. A free-running stall-cycle counter is included for performance monitoring.

---
 rtl/pipeline_ctrl.sv | 125 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline stall vector, trap/mret sequencer and stall-cycle counter
module pipeline_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic [WIDTH-1:0] exception,
  input  logic [WIDTH-1:0] exc_pc,
  input  logic [WIDTH-1:0] mtvec,
  input  logic [WIDTH-1:0] mepc,
  output logic [4:0]       ctrl_stall,
  output logic             ctrl_flush,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             csr_trap_we,
  output logic             csr_mret,
  output logic [WIDTH-1:0] csr_mepc_out,
  output logic [WIDTH-1:0] csr_mcause_out,
  output logic [WIDTH-1:0] stall_cycles
);

  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, FLUSH = 2'd2} state_t;

  state_t           state;
  logic             lat_mret;
  logic [3:0]       lat_cause;
  logic [WIDTH-1:0] lat_pc;

  logic             exc_any;
  logic             exc_mret;
  logic [3:0]       exc_cause;
  logic             fire_go;
  logic             fire_mret;
  logic [3:0]       fire_cause;
  logic [WIDTH-1:0] fire_pc;
  logic             unused;

  assign unused = ^{exception, mtvec[1:0]};

  // Cause priority: illegal > ecall > ebreak > mret
  always_comb begin
    exc_any   = |exception[3:0];
    exc_mret  = 1'b0;
    exc_cause = 4'd0;
    if (exception[0])      exc_cause = 4'd2;
    else if (exception[1]) exc_cause = 4'd11;
    else if (exception[2]) exc_cause = 4'd3;
    else                   exc_mret  = exception[3];
  end

  always_comb begin
    ctrl_stall = 5'b00000;
    if (state != FLUSH) begin
      if (stallreq_mem)     ctrl_stall = 5'b11111;
      else if (stallreq_ex) ctrl_stall = 5'b01111;
      else if (stallreq_id) ctrl_stall = 5'b00111;
      else if (stallreq_if) ctrl_stall = 5'b00011;
    end
  end

  // A trap fires straight from IDLE or out of PEND once memory is no longer stalling
  assign fire_go    = !stallreq_mem && ((state == IDLE && exc_any) || state == PEND);
  assign fire_mret  = (state == PEND) ? lat_mret  : exc_mret;
  assign fire_cause = (state == PEND) ? lat_cause : exc_cause;
  assign fire_pc    = (state == PEND) ? lat_pc    : exc_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      lat_mret       <= 1'b0;
      lat_cause      <= 4'd0;
      lat_pc         <= '0;
      ctrl_flush     <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      csr_trap_we    <= 1'b0;
      csr_mret       <= 1'b0;
      csr_mepc_out   <= '0;
      csr_mcause_out <= '0;
      stall_cycles   <= '0;
    end else begin
      ctrl_flush     <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      csr_trap_we    <= 1'b0;
      csr_mret       <= 1'b0;
      csr_mepc_out   <= '0;
      csr_mcause_out <= '0;
      if (ctrl_stall[0]) stall_cycles <= stall_cycles + WIDTH'(1);

      case (state)
        IDLE: begin
          if (exc_any) begin
            lat_mret  <= exc_mret;
            lat_cause <= exc_cause;
            lat_pc    <= exc_pc;
            if (stallreq_mem) state <= PEND;
          end
        end
        FLUSH:   state <= IDLE;
        default: ;
      endcase

      if (fire_go) begin
        state          <= FLUSH;
        ctrl_flush     <= 1'b1;
        redirect_valid <= 1'b1;
        if (fire_mret) begin
          csr_mret    <= 1'b1;
          redirect_pc <= mepc;
        end else begin
          csr_trap_we    <= 1'b1;
          csr_mepc_out   <= fire_pc;
          csr_mcause_out <= WIDTH'(fire_cause);
          redirect_pc    <= {mtvec[WIDTH-1:2], 2'b00};
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sif, sid, sex, smem;
  logic [31:0] exception, exc_pc, mtvec, mepc;
  logic [4:0]  ctrl_stall;
  logic        ctrl_flush, redirect_valid, csr_trap_we, csr_mret;
  logic [31:0] redirect_pc, csr_mepc_out, csr_mcause_out, stall_cycles;

  logic        w_req;
  logic [4:0]  w_stall;
  logic        w_flush, w_rv, w_trap, w_mret;
  logic [3:0]  w_rpc, w_mepc, w_mcause, w_cnt;

  pipeline_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .stallreq_if(sif), .stallreq_id(sid), .stallreq_ex(sex), .stallreq_mem(smem),
    .exception(exception), .exc_pc(exc_pc), .mtvec(mtvec), .mepc(mepc),
    .ctrl_stall(ctrl_stall), .ctrl_flush(ctrl_flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .csr_trap_we(csr_trap_we), .csr_mret(csr_mret),
    .csr_mepc_out(csr_mepc_out), .csr_mcause_out(csr_mcause_out), .stall_cycles(stall_cycles)
  );

  // Narrow instance so the counter wrap is reachable in a few cycles
  pipeline_ctrl #(.WIDTH(4)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .stallreq_if(w_req), .stallreq_id(1'b0), .stallreq_ex(1'b0), .stallreq_mem(1'b0),
    .exception(4'h0), .exc_pc(4'h0), .mtvec(4'h0), .mepc(4'h0),
    .ctrl_stall(w_stall), .ctrl_flush(w_flush), .redirect_valid(w_rv),
    .redirect_pc(w_rpc), .csr_trap_we(w_trap), .csr_mret(w_mret),
    .csr_mepc_out(w_mepc), .csr_mcause_out(w_mcause), .stall_cycles(w_cnt)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model state
  bit          m_known = 0;
  bit          m_flush = 0;
  bit          m_pend = 0;
  bit          m_pmret = 0;
  int          m_pcause = 0;
  logic [31:0] m_ppc = '0;
  logic [31:0] m_cnt = '0;
  logic [4:0]  last_stall;

  // Number of held stages is (highest requester index + 2); the vector is that many low ones
  function automatic logic [4:0] stall_rule(input logic [3:0] r);
    int n;
    n = r[3] ? 5 : r[2] ? 4 : r[1] ? 3 : r[0] ? 2 : 0;
    return 5'((1 << n) - 1);
  endfunction

  // Returns mcause, 0 for mret, -1 for nothing
  function automatic int code_of(input logic [31:0] e);
    if (e[0]) return 2;
    if (e[1]) return 11;
    if (e[2]) return 3;
    if (e[3]) return 0;
    return -1;
  endfunction

  // r = {mem, ex, id, if}
  task automatic apply_cycle(input logic [3:0] r, input logic [31:0] exc, input logic rn);
    logic [4:0]  exp_stall;
    int          code, f_cause;
    bit          fire, f_mret;
    logic [31:0] f_pc, e_rpc;
    {smem, sex, sid, sif} = r;
    exception = exc;
    rst_n = rn;
    #1;
    exp_stall = m_flush ? 5'd0 : stall_rule(r);
    last_stall = ctrl_stall;
    if (m_known) chk("ctrl_stall", {27'd0, ctrl_stall}, {27'd0, exp_stall});
    @(posedge clk);
    fire = 0; f_mret = 0; f_cause = 0; f_pc = '0;
    if (!rn) begin
      m_known = 1; m_flush = 0; m_pend = 0; m_cnt = '0;
    end else begin
      if (exp_stall[0]) m_cnt = m_cnt + 32'd1;
      code = code_of(exc);
      if (m_flush) m_flush = 0;
      else if (m_pend) begin
        if (!r[3]) begin
          fire = 1; f_mret = m_pmret; f_cause = m_pcause; f_pc = m_ppc; m_pend = 0;
        end
      end else if (code >= 0) begin
        if (r[3]) begin
          m_pend = 1; m_pmret = (code == 0); m_pcause = code; m_ppc = exc_pc;
        end else begin
          fire = 1; f_mret = (code == 0); f_cause = code; f_pc = exc_pc;
        end
      end
      if (fire) m_flush = 1;
    end
    e_rpc = !fire ? 32'd0 : f_mret ? mepc : (mtvec & ~32'h3);
    #1;
    if (m_known) begin
      chk("ctrl_flush", {31'd0, ctrl_flush}, {31'd0, fire});
      chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, fire});
      chk("redirect_pc", redirect_pc, e_rpc);
      chk("csr_trap_we", {31'd0, csr_trap_we}, {31'd0, fire && !f_mret});
      chk("csr_mret", {31'd0, csr_mret}, {31'd0, fire && f_mret});
      chk("csr_mepc_out", csr_mepc_out, (fire && !f_mret) ? f_pc : 32'd0);
      chk("csr_mcause_out", csr_mcause_out, (fire && !f_mret) ? 32'(f_cause) : 32'd0);
      chk("stall_cycles", stall_cycles, m_cnt);
    end
  endtask

  typedef struct {
    logic [3:0] req;
    logic [4:0] stall;
  } vec_t;

  vec_t tbl[10];
  int   n_stalled;

  initial begin
    tbl[0] = '{4'b0000, 5'b00000};
    tbl[1] = '{4'b0001, 5'b00011};
    tbl[2] = '{4'b0010, 5'b00111};
    tbl[3] = '{4'b0011, 5'b00111};
    tbl[4] = '{4'b0100, 5'b01111};
    tbl[5] = '{4'b0101, 5'b01111};
    tbl[6] = '{4'b1000, 5'b11111};
    tbl[7] = '{4'b1001, 5'b11111};
    tbl[8] = '{4'b1111, 5'b11111};
    tbl[9] = '{4'b0000, 5'b00000};

    rst_n = 1'b0; sif = 0; sid = 0; sex = 0; smem = 0; w_req = 0;
    exception = '0; exc_pc = '0; mtvec = '0; mepc = '0;

    apply_cycle(4'b0000, 32'h0, 1'b0);
    apply_cycle(4'b0000, 32'h0, 1'b0);
    chk("reset_flush", {31'd0, ctrl_flush}, 32'd0);
    chk("reset_count", stall_cycles, 32'd0);

    n_stalled = 0;
    for (int i = 0; i < 10; i++) begin
      apply_cycle(tbl[i].req, 32'h0, 1'b1);
      chk("stall_table", {27'd0, last_stall}, {27'd0, tbl[i].stall});
      if (tbl[i].stall != 5'd0) n_stalled++;
    end
    chk("stall_count", stall_cycles, 32'(n_stalled));

    // ecall
    exc_pc = 32'h0000_0100; mtvec = 32'h0000_0803;
    apply_cycle(4'b0000, 32'h2, 1'b1);
    chk("ecall_flush", {31'd0, ctrl_flush}, 32'd1);
    chk("ecall_rpc", redirect_pc, 32'h0000_0800);
    chk("ecall_we", {31'd0, csr_trap_we}, 32'd1);
    chk("ecall_cause", csr_mcause_out, 32'd11);
    chk("ecall_mepc", csr_mepc_out, 32'h100);
    apply_cycle(4'b0000, 32'h0, 1'b1);
    chk("ecall_clear", {ctrl_flush, csr_trap_we, redirect_pc[29:0]}, 32'd0);

    // Pending illegal instruction behind a memory stall
    apply_cycle(4'b1000, 32'h1, 1'b1);
    chk("pend_noflush0", {31'd0, ctrl_flush}, 32'd0);
    apply_cycle(4'b1000, 32'h0, 1'b1);
    apply_cycle(4'b1000, 32'h0, 1'b1);
    chk("pend_noflush2", {31'd0, ctrl_flush}, 32'd0);
    apply_cycle(4'b0000, 32'h0, 1'b1);
    chk("pend_flush", {31'd0, ctrl_flush}, 32'd1);
    chk("pend_cause", csr_mcause_out, 32'd2);
    apply_cycle(4'b0000, 32'h0, 1'b1);
    chk("pend_once", {31'd0, ctrl_flush}, 32'd0);

    // mret and priority
    mepc = 32'h0000_0200;
    apply_cycle(4'b0000, 32'h8, 1'b1);
    chk("mret_strobe", {31'd0, csr_mret}, 32'd1);
    chk("mret_rpc", redirect_pc, 32'h200);
    chk("mret_nowe", {31'd0, csr_trap_we}, 32'd0);
    apply_cycle(4'b0000, 32'h0, 1'b1);
    apply_cycle(4'b0000, 32'h9, 1'b1);
    chk("prio_we", {31'd0, csr_trap_we}, 32'd1);
    chk("prio_cause", csr_mcause_out, 32'd2);
    chk("prio_nomret", {31'd0, csr_mret}, 32'd0);
    apply_cycle(4'b0000, 32'h0, 1'b1);

    // Flush overrides an EX stall; exception during FLUSH is dropped
    apply_cycle(4'b0100, 32'h0, 1'b1);
    chk("ovr_before", {27'd0, last_stall}, 32'h0f);
    apply_cycle(4'b0100, 32'h2, 1'b1);
    apply_cycle(4'b0100, 32'h1, 1'b1);
    chk("ovr_during", {27'd0, last_stall}, 32'h00);
    chk("ovr_ignored", {31'd0, ctrl_flush}, 32'd0);
    apply_cycle(4'b0100, 32'h0, 1'b1);
    chk("ovr_after", {27'd0, last_stall}, 32'h0f);
    chk("ovr_still_idle", {31'd0, ctrl_flush}, 32'd0);

    // Reset while in PEND discards the trap
    apply_cycle(4'b1000, 32'h2, 1'b1);
    apply_cycle(4'b1000, 32'h0, 1'b0);
    chk("rstp_count", stall_cycles, 32'd0);
    apply_cycle(4'b0000, 32'h0, 1'b1);
    chk("rstp_noflush", {31'd0, ctrl_flush}, 32'd0);
    chk("rstp_norv", {31'd0, redirect_valid}, 32'd0);

    // Counter wrap on the narrow instance
    w_req = 1'b1;
    repeat (15) apply_cycle(4'b0000, 32'h0, 1'b1);
    chk("wrap_full", {28'd0, w_cnt}, 32'hf);
    apply_cycle(4'b0000, 32'h0, 1'b1);
    chk("wrap_zero", {28'd0, w_cnt}, 32'h0);
    w_req = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [3:0]  r;
      logic [31:0] e;
      r = {($urandom_range(0, 2) == 0), 3'($urandom)};
      e = ($urandom_range(0, 9) < 6) ? 32'h0 : ($urandom & 32'hffff_fff0) | 32'($urandom_range(0, 15));
      exc_pc = $urandom; mtvec = $urandom; mepc = $urandom;
      apply_cycle(r, e, $urandom_range(0, 39) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
